// File: rtl/data_ram_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_ram_responder
// Brief    : Data-memory responder with byte-lane writes, programmable wait
//            states and a pipeline stall that holds the request until commit.
// Revision : 1.0
// ============================================================================
module data_ram_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        ram_en,
  input  logic [3:0]  ram_write_en,
  input  logic [31:0] ram_addr,
  input  logic [31:0] ram_write_data,
  output logic [31:0] ram_read_data,
  output logic        ram_stall,
  output logic        ram_busy
);

  localparam int         c_DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [3:0] c_WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [3:0]              we_q, we_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [31:0]             rdata_q;
  logic [31:0]             mem_q [0:c_DEPTH-1];

  logic                    w_stall;
  logic                    w_commit;
  logic [3:0]              w_cmt_we;
  logic [ADDR_WIDTH-1:0]   w_cmt_idx;
  logic [31:0]             w_cmt_wdata;
  logic [ADDR_WIDTH-1:0]   w_in_idx;

  assign w_in_idx = ram_addr[ADDR_WIDTH+1:2];

  // Address bits outside the word index are deliberately ignored (aliasing).
  logic w_unused_lo;
  assign w_unused_lo = ^ram_addr[1:0];
  if (ADDR_WIDTH < 30) begin : g_addr_hi
    logic w_unused_hi;
    assign w_unused_hi = ^ram_addr[31:ADDR_WIDTH+2];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    w_stall     = 1'b0;
    w_commit    = 1'b0;
    w_cmt_we    = we_q;
    w_cmt_idx   = idx_q;
    w_cmt_wdata = wdata_q;
    case (state_q)
      ST_IDLE: begin
        w_stall = ram_en;
        if (ram_en && !flush) begin
          we_d    = ram_write_en;
          idx_d   = w_in_idx;
          wdata_d = ram_write_data;
          cnt_d   = c_WAIT_LOAD;
          if (c_WAIT_LOAD == 4'd0) begin
            // Zero wait states: commit straight from the live request.
            state_d     = ST_DONE;
            w_commit    = 1'b1;
            w_cmt_we    = ram_write_en;
            w_cmt_idx   = w_in_idx;
            w_cmt_wdata = ram_write_data;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        w_stall = 1'b1;
        if (flush) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d  = ST_DONE;
            w_commit = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // RAM array has no reset so it can map onto block memory.
  always_ff @(posedge clk) begin
    if (rst && w_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (w_cmt_we[i]) begin
          mem_q[w_cmt_idx][8*i +: 8] <= w_cmt_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata_q <= 32'd0;
    end else if (w_commit) begin
      rdata_q <= (w_cmt_we == 4'd0) ? mem_q[w_cmt_idx] : 32'd0;
    end
  end

  assign ram_read_data = rdata_q;
  assign ram_stall     = rst & w_stall;
  assign ram_busy      = rst & (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_data_ram_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_ram_responder
// Brief    : Self-checking bench for data_ram_responder (2 and 0 wait states).
// Revision : 1.0
// ============================================================================
module tb_data_ram_responder;

  logic        clk = 1'b0;
  logic        rst, flush, en2, en0;
  logic [3:0]  we;
  logic [31:0] addr, wdata;
  logic [31:0] rd2, rd0;
  logic        st2, st0, bz2, bz0;

  always #5 clk = ~clk;

  data_ram_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) u2 (
    .clk(clk), .rst(rst), .flush(flush), .ram_en(en2), .ram_write_en(we),
    .ram_addr(addr), .ram_write_data(wdata), .ram_read_data(rd2),
    .ram_stall(st2), .ram_busy(bz2)
  );

  data_ram_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .rst(rst), .flush(flush), .ram_en(en0), .ram_write_en(we),
    .ram_addr(addr), .ram_write_data(wdata), .ram_read_data(rd0),
    .ram_stall(st0), .ram_busy(bz0)
  );

  typedef struct {
    bit          sel0;
    logic [31:0] a;
    logic [3:0]  w;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] last2 = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue one request and hold it until the DUT reaches DONE.
  task automatic access(input bit sel0, input logic [31:0] a, input logic [3:0] w,
                        input logic [31:0] d, input logic [31:0] exp);
    int          stalls = 0;
    bit          done = 0;
    logic        s, b;
    logic [31:0] r;
    int          lat;
    addr = a; we = w; wdata = d;
    if (sel0) en0 = 1'b1; else en2 = 1'b1;
    sb.push_back(exp);
    lat = sel0 ? 1 : 3;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      s = sel0 ? st0 : st2;
      b = sel0 ? bz0 : bz2;
      r = sel0 ? rd0 : rd2;
      if (s) begin
        stalls++;
      end else begin
        done = 1;
        chk("done_busy", 32'(b), 32'd1);
        chk("stall_cycles", 32'(stalls), 32'(lat));
        if (sb.size() == 0) chk("scoreboard_empty", 32'd1, 32'd0);
        else chk("rdata", r, sb.pop_front());
      end
    end
    if (!done) begin
      chk("access_timeout", 32'(stalls), 32'(lat));
      if (sb.size() != 0) void'(sb.pop_front());
    end
    if (!sel0) last2 = exp;
    en0 = 1'b0; en2 = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; en2 = 1'b1; en0 = 1'b1;
    we = 4'd0; addr = 32'd0; wdata = 32'd0;

    // Reset: outputs held low even with a request pending.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall2", 32'(st2), 32'd0);
    chk("rst_busy2", 32'(bz2), 32'd0);
    chk("rst_stall0", 32'(st0), 32'd0);
    chk("rst_rdata2", rd2, 32'd0);
    chk("rst_rdata0", rd0, 32'd0);
    en2 = 1'b0; en0 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    vecs = '{
      '{0, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 32'h0000_0000},
      '{0, 32'h0000_0010, 4'h0, 32'h0000_0000, 32'hDEAD_BEEF},
      '{0, 32'h0000_0020, 4'hF, 32'h1122_3344, 32'h0000_0000},
      '{0, 32'h0000_0020, 4'b0100, 32'h00AA_0000, 32'h0000_0000},
      '{0, 32'h0000_0023, 4'h0, 32'h0000_0000, 32'h11AA_3344},
      '{0, 32'h0000_1000, 4'hF, 32'h5A5A_5A5A, 32'h0000_0000},
      '{0, 32'h0000_0000, 4'h0, 32'h0000_0000, 32'h5A5A_5A5A},
      '{0, 32'h0000_0044, 4'hF, 32'hA1B2_C3D4, 32'h0000_0000},
      '{0, 32'h0000_0044, 4'b1001, 32'hEE00_00FF, 32'h0000_0000},
      '{0, 32'h0000_0044, 4'h0, 32'h0000_0000, 32'hEEB2_C3FF},
      '{0, 32'h0000_0030, 4'hF, 32'h0123_4567, 32'h0000_0000},
      '{1, 32'h0000_0000, 4'hF, 32'h1357_9BDF, 32'h0000_0000},
      '{1, 32'h0000_0004, 4'hF, 32'h2468_ACE0, 32'h0000_0000},
      '{1, 32'h0000_0000, 4'h0, 32'h0000_0000, 32'h1357_9BDF},
      '{1, 32'h0000_0004, 4'h0, 32'h0000_0000, 32'h2468_ACE0}
    };
    foreach (vecs[i]) access(vecs[i].sel0, vecs[i].a, vecs[i].w, vecs[i].d, vecs[i].exp);

    // Flush in IDLE: stall follows ram_en, but nothing is accepted.
    addr = 32'h30; we = 4'hF; wdata = 32'h0BAD_0BAD; en2 = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("idle_flush_stall", 32'(st2), 32'd1);
    @(posedge clk); #1;
    en2 = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("idle_flush_busy", 32'(bz2), 32'd0);
    @(posedge clk); #1;

    // Flush in the last WAIT cycle of a write.
    addr = 32'h30; we = 4'hF; wdata = 32'hCAFE_F00D; en2 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_wait_stall", 32'(st2), 32'd1);
    @(posedge clk); #1;
    flush = 1'b0; en2 = 1'b0;
    @(negedge clk);
    chk("flush_after_stall", 32'(st2), 32'd0);
    chk("flush_after_busy", 32'(bz2), 32'd0);
    chk("flush_rdata_hold", rd2, last2);
    @(posedge clk); #1;
    access(0, 32'h30, 4'h0, 32'h0, 32'h0123_4567);

    // Reset in the last WAIT cycle of a write.
    addr = 32'h30; we = 4'hF; wdata = 32'hFFFF_FFFF; en2 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstwait_stall", 32'(st2), 32'd0);
    chk("rstwait_busy", 32'(bz2), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1; en2 = 1'b0;
    @(negedge clk);
    chk("rstwait_rdata", rd2, 32'd0);
    chk("rstwait_idle", 32'(bz2), 32'd0);
    @(posedge clk); #1;
    access(0, 32'h30, 4'h0, 32'h0, 32'h0123_4567);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_ram_responder.md
Name: data_ram_responder

Overview:
- Responder end of the data-memory request interface driven by the MEM stage: `ram_en`, `ram_write_en`, `ram_addr`, `ram_write_data`.
- Holds a word-organised data RAM with per-byte write enables and a configurable number of wait states.
- Returns read data to the WB stage and drives `ram_stall` so the pipeline freezes with the request held stable until the access completes.
- Sits between the MEM stage and the WB stage, and replaces the ideal zero-latency RAM used in simulation.

Parameters:
- ADDR_WIDTH, 10, word-address bits; RAM depth is 2^ADDR_WIDTH 32-bit words.
- WAIT_CYCLES, 2, extra wait states per access (0..15); total stall cycles per access = WAIT_CYCLES+1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-low
- flush  input  1  pipeline flush (exception/ERET); aborts an in-flight access
- ram_en  input  1  access request from MEM stage
- ram_write_en  input  4  byte write enables; 4'b0000 = read
- ram_addr  input  32  word-aligned byte address; bits [1:0] ignored
- ram_write_data  input  32  write data, pre-shifted into byte lanes
- ram_read_data  output  32  read word, valid while state=DONE and the access was a read
- ram_stall  output  1  high while a request is pending and not yet complete
- ram_busy  output  1  high in WAIT or DONE (debug/perf counter)

Behaviour:
- Reset: when `rst`=0 at a rising edge, state=IDLE, counter=0, latched request cleared, `ram_read_data`=0; `ram_stall`=0 and `ram_busy`=0 while `rst`=0. RAM contents are not reset.
- Index: `ram_addr[ADDR_WIDTH+1:2]`. Higher address bits are ignored, so addresses alias.
- States:
  - IDLE:
    - `ram_stall` = `ram_en`.
    - If `ram_en`=1 and `flush`=0: latch addr/we/wdata and load counter=WAIT_CYCLES.
    - Go to DONE if WAIT_CYCLES=0, else go to WAIT.
  - WAIT:
    - `ram_stall`=1.
    - Inputs are ignored; the latched request is used.
    - Counter decrements each cycle. When counter==1, the next state is DONE.
  - DONE:
    - `ram_stall`=0, so the pipeline advances this cycle.
    - `ram_read_data` holds the result.
    - Next state is IDLE unconditionally. A new request is accepted on the following IDLE cycle.
- Access commit happens on the clock edge that enters DONE:
  - Write: each byte lane i with we[i]=1 is updated from wdata[8i+7:8i]; other lanes are unchanged.
  - Read (we=0): `ram_read_data` <= mem[index].
  - Write: `ram_read_data` <= 0.
- Stall timing: a request seen in IDLE at cycle 0 gives `ram_stall`=1 for cycles 0..WAIT_CYCLES and 0 at cycle WAIT_CYCLES+1 (DONE).
- Flush:
  - `flush`=1 in IDLE or WAIT → state IDLE next edge, no RAM write, `ram_read_data` unchanged.
  - `flush` in DONE has no effect, because the access already committed.
- Reset during WAIT → IDLE, no write performed.
- `ram_en`=0 in IDLE → remain IDLE, `ram_stall`=0, `ram_read_data` holds its last value.
- Partial/zero write enables are legal. `we`=4'b0000 is always a read.
- `ram_busy` = (state != IDLE).

Test Plan:
- WAIT_CYCLES=2: write 0xDEADBEEF to addr 0x10 with we=4'b1111, then read 0x10 → stall high exactly 3 cycles for each access; read returns 0xDEADBEEF in DONE.
- Byte lanes: preload 0x11223344 at 0x20; write we=4'b0100, data 0x00AA0000 → subsequent read returns 0x11AA3344.
- WAIT_CYCLES=0: back-to-back reads of 0x0 and 0x4 → each stalls exactly 1 cycle; DONE and IDLE alternate; both data words are correct.
- Flush in WAIT during a write of 0xCAFEF00D to 0x30 → state returns to IDLE, stall drops next cycle, later read of 0x30 returns the old value.
- `rst`=0 asserted mid-WAIT on a write → outputs 0 and state IDLE; after release, the read of the target address shows the prior contents unchanged.
- Aliasing with ADDR_WIDTH=10: write 0x5A5A5A5A to 0x1000 → read of 0x0 returns 0x5A5A5A5A.
